// File: rtl/fwd_hazard_unit.sv
// Multi-stage operand forwarding and load-use stall unit. Selects and stall are
// combinational on the current issue slot; the tracker updates at the clock edge.
module fwd_hazard_unit #(
  parameter  int DEPTH    = 3,
  parameter  int LOAD_LAT = 1,
  parameter  int CNT_W    = 16,
  localparam int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_instr,
  input  logic             id_valid,
  input  logic             flush,
  output logic [SEL_W-1:0] fwd_sel_a,
  output logic [SEL_W-1:0] fwd_sel_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       ld;
  } ent_t;

  ent_t             r_ent [1:DEPTH];
  logic [CNT_W-1:0] r_cnt;

  logic [6:0]       w_opc;
  logic [4:0]       w_rs1;
  logic [4:0]       w_rs2;
  logic [4:0]       w_rd;
  logic             w_is_load;
  logic [SEL_W-1:0] w_sel_a;
  logic [SEL_W-1:0] w_sel_b;
  logic             w_haz_a;
  logic             w_haz_b;
  logic             w_stall;
  logic             w_push;
  logic             w_unused_bits;

  assign w_unused_bits = ^{id_instr[31:25], id_instr[14:12]};

  always_comb begin
    w_opc     = id_instr[6:0];
    w_rs1     = 5'd0;
    w_rs2     = 5'd0;
    w_rd      = 5'd0;
    w_is_load = (w_opc == OP_LOAD);
    if (w_opc inside {OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_JALR})
      w_rs1 = id_instr[19:15];
    if (w_opc inside {OP_R, OP_S, OP_B})
      w_rs2 = id_instr[24:20];
    if (w_opc inside {OP_R, OP_I, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR})
      w_rd = id_instr[11:7];
  end

  // Scan oldest to youngest so the lowest matching stage overwrites the rest.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    w_haz_a = 1'b0;
    w_haz_b = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (w_rs1 != 5'd0 && r_ent[k].vld && r_ent[k].rd == w_rs1) begin
        w_sel_a = SEL_W'(k);
        w_haz_a = r_ent[k].ld && (k <= LOAD_LAT);
      end
      if (w_rs2 != 5'd0 && r_ent[k].vld && r_ent[k].rd == w_rs2) begin
        w_sel_b = SEL_W'(k);
        w_haz_b = r_ent[k].ld && (k <= LOAD_LAT);
      end
    end
  end

  assign w_stall = id_valid && !flush && (w_haz_a || w_haz_b);
  assign w_push  = id_valid && !flush && !w_stall && (w_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++)
        r_ent[k] <= '0;
      r_cnt <= '0;
    end else begin
      r_ent[1] <= w_push ? ent_t'{vld: 1'b1, rd: w_rd, ld: w_is_load} : ent_t'('0);
      for (int k = 2; k <= DEPTH; k++)
        r_ent[k] <= r_ent[k-1];
      if (w_stall && r_cnt != '1)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign fwd_sel_a   = w_sel_a;
  assign fwd_sel_b   = w_sel_b;
  assign stall       = w_stall;
  assign stall_count = r_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed checks of forwarding selects, load-use stalls and the stall counter.
module tb_fwd_hazard_unit;

  localparam logic [31:0] ADD_X5   = 32'h002082B3; // add x5,x1,x2
  localparam logic [31:0] SUB_X6   = 32'h40328333; // sub x6,x5,x3
  localparam logic [31:0] LW_X7    = 32'h0000A383; // lw x7,0(x1)
  localparam logic [31:0] ADD_X8   = 32'h00738433; // add x8,x7,x7
  localparam logic [31:0] ADDI_X0  = 32'h00100013; // addi x0,x0,1
  localparam logic [31:0] ADD_X0X0 = 32'h00000433; // add x8,x0,x0
  localparam logic [31:0] SW_IMM4  = 32'h0050A223; // sw x5,4(x1)
  localparam logic [31:0] ADD_X4X4 = 32'h00420433; // add x8,x4,x4
  localparam logic [31:0] BEQ_8    = 32'h00208463; // beq x1,x2,8
  localparam logic [31:0] ADD_X8X8 = 32'h008404B3; // add x9,x8,x8
  localparam logic [31:0] ADD_X6W  = 32'h00208333; // add x6,x1,x2
  localparam logic [31:0] ADDI_X9  = 32'h00628493; // addi x9,x5,6

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        flush;
  logic [1:0]  fwd_sel_a, fwd_sel_b, fwd_sel_a2, fwd_sel_b2;
  logic        stall, stall2;
  logic [15:0] stall_count;
  logic [1:0]  stall_count2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.DEPTH(3), .LOAD_LAT(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid), .flush(flush),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall(stall), .stall_count(stall_count)
  );

  // Longer load latency and a tiny counter to reach multi-cycle stalls and saturation.
  fwd_hazard_unit #(.DEPTH(3), .LOAD_LAT(2), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid), .flush(flush),
    .fwd_sel_a(fwd_sel_a2), .fwd_sel_b(fwd_sel_b2), .stall(stall2), .stall_count(stall_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [31:0] instr, input logic vld, input logic fl);
    id_instr = instr;
    id_valid = vld;
    flush    = fl;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) begin
      drive(32'h0, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(32'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_sel_a", 32'(fwd_sel_a), 0);
    chk("rst_sel_b", 32'(fwd_sel_b), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_count", 32'(stall_count), 0);
    rst = 1'b0;

    // Back-to-back dependency
    drive(ADD_X5, 1'b1, 1'b0);
    chk("t1_prod_stall", 32'(stall), 0);
    tick();
    drive(SUB_X6, 1'b1, 1'b0);
    chk("t1_sel_a", 32'(fwd_sel_a), 1);
    chk("t1_sel_b", 32'(fwd_sel_b), 0);
    chk("t1_stall", 32'(stall), 0);
    tick();
    drain();

    // Producer aged by bubbles
    for (int nb = 1; nb <= 4; nb++) begin
      drive(ADD_X5, 1'b1, 1'b0);
      tick();
      for (int b = 0; b < nb; b++) begin
        drive(32'h0, 1'b0, 1'b0);
        tick();
      end
      drive(SUB_X6, 1'b1, 1'b0);
      chk($sformatf("t2_sel_a_gap%0d", nb), 32'(fwd_sel_a), (nb < 3) ? nb + 1 : 0);
      tick();
      drain();
    end

    // Load-use: one stall cycle, then forward from stage 2
    drive(LW_X7, 1'b1, 1'b0);
    chk("t3_lw_stall", 32'(stall), 0);
    tick();
    drive(ADD_X8, 1'b1, 1'b0);
    chk("t3_stall_on", 32'(stall), 1);
    chk("t3_sel_a_s1", 32'(fwd_sel_a), 1);
    chk("t3_sel_b_s1", 32'(fwd_sel_b), 1);
    tick();
    chk("t3_stall_off", 32'(stall), 0);
    chk("t3_sel_a", 32'(fwd_sel_a), 2);
    chk("t3_sel_b", 32'(fwd_sel_b), 2);
    chk("t3_count", 32'(stall_count), 1);
    tick();
    drive(ADD_X8X8, 1'b1, 1'b0);
    chk("t3_add_recorded", 32'(fwd_sel_a), 1);
    chk("t3_count_hold", 32'(stall_count), 1);
    tick();
    drain();

    // Youngest writer wins
    drive(ADD_X5, 1'b1, 1'b0);
    tick();
    drive(ADD_X5, 1'b1, 1'b0);
    tick();
    drive(SUB_X6, 1'b1, 1'b0);
    chk("t4_youngest", 32'(fwd_sel_a), 1);
    tick();
    drain();

    // No-rd producers and x0 never forward
    drive(ADDI_X0, 1'b1, 1'b0);
    tick();
    drive(ADD_X0X0, 1'b1, 1'b0);
    chk("t5_x0_a", 32'(fwd_sel_a), 0);
    chk("t5_x0_b", 32'(fwd_sel_b), 0);
    tick();
    drain();
    drive(SW_IMM4, 1'b1, 1'b0);
    tick();
    drive(ADD_X4X4, 1'b1, 1'b0);
    chk("t5_sw_a", 32'(fwd_sel_a), 0);
    chk("t5_sw_b", 32'(fwd_sel_b), 0);
    tick();
    drain();
    drive(BEQ_8, 1'b1, 1'b0);
    tick();
    drive(ADD_X8X8, 1'b1, 1'b0);
    chk("t5_beq_a", 32'(fwd_sel_a), 0);
    tick();
    drain();
    drive(ADD_X6W, 1'b1, 1'b0);
    tick();
    drive(ADDI_X9, 1'b1, 1'b0);
    chk("t5_itype_no_rs2", 32'(fwd_sel_b), 0);
    tick();
    drain();

    // Flush beats stall and is not recorded
    drive(LW_X7, 1'b1, 1'b0);
    tick();
    drive(ADD_X8, 1'b1, 1'b1);
    chk("t6_flush_stall", 32'(stall), 0);
    tick();
    drive(ADD_X8X8, 1'b1, 1'b0);
    chk("t6_flush_norec", 32'(fwd_sel_a), 0);
    chk("t6_flush_count", 32'(stall_count), 1);
    tick();
    drain();

    // Reset during a stall
    drive(LW_X7, 1'b1, 1'b0);
    tick();
    drive(ADD_X8, 1'b1, 1'b0);
    chk("t6_pre_rst_stall", 32'(stall), 1);
    rst = 1'b1;
    tick();
    chk("t6_rst_stall", 32'(stall), 0);
    chk("t6_rst_sel_a", 32'(fwd_sel_a), 0);
    chk("t6_rst_sel_b", 32'(fwd_sel_b), 0);
    chk("t6_rst_count", 32'(stall_count), 0);
    rst = 1'b0;
    drain();

    // LOAD_LAT=2 instance: two stall cycles per load-use, counter saturates
    for (int rep = 0; rep < 2; rep++) begin
      drive(LW_X7, 1'b1, 1'b0);
      tick();
      drive(ADD_X8, 1'b1, 1'b0);
      chk($sformatf("l2_stall1_r%0d", rep), 32'(stall2), 1);
      tick();
      chk($sformatf("l2_stall2_r%0d", rep), 32'(stall2), 1);
      chk($sformatf("l2_sel2_r%0d", rep), 32'(fwd_sel_a2), 2);
      tick();
      chk($sformatf("l2_release_r%0d", rep), 32'(stall2), 0);
      chk($sformatf("l2_sel3_r%0d", rep), 32'(fwd_sel_b2), 3);
      chk($sformatf("l2_count_r%0d", rep), 32'(stall_count2), (rep == 0) ? 2 : 3);
      tick();
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
